// File: rtl/avmm_s_arb2.sv
// ----------------------------------------------------------------------------
// avmm_s_arb2
//
// Two-requester round-robin arbiter in front of one 32-bit Avalon-MM slave
// port. One requester owns the slave at a time, and it keeps ownership for a
// whole transfer. Command, readdata and waitrequest pass straight through to
// the owner. A watchdog aborts a transfer that stalls too long, so a hung
// slave cannot lock out either requester.
//
// Parameters:
//   TIMEOUT   - stalled grant cycles allowed before an abort (0 = no watchdog)
//   ERR_DATA  - readdata returned to the owner in the abort cycle
//
// Ports:
//   clk_clk, reset_reset            - clock, synchronous active-high reset
//   m0_* / m1_*                     - requester command (address, read, write,
//                                     writedata) and response (readdata,
//                                     waitrequest)
//   s_*                             - command to / response from the slave
//   timeout_err                     - high during an abort cycle
//   timeout_cnt                     - saturating number of aborts
// ----------------------------------------------------------------------------
module avmm_s_arb2 #(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_clk,
    input  logic        reset_reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic        timeout_err,
    output logic [7:0]  timeout_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    // Watchdog counter only needs to reach TIMEOUT; it never goes past it
    // because an abort always returns to IDLE.
    localparam int              WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic            last;
    logic            next_last;
    logic [WD_W-1:0] wd;
    logic [7:0]      err_cnt;

    logic            req_0;
    logic            req_1;
    logic            granted;
    logic            owner;
    logic            own_req;
    logic            own_read;
    logic            own_write;
    logic [31:0]     own_address;
    logic [31:0]     own_writedata;
    logic            abort;
    logic            resp_wait;
    logic [31:0]     resp_data;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // Reset gates the grant combinationally so the slave sees an idle bus
    // and both requesters see waitrequest from the very cycle reset is high,
    // not only after the clock edge that clears the state.
    assign granted = ((state == GNT0) || (state == GNT1)) && !reset_reset;
    assign owner   = (state == GNT1);

    // Command of whichever requester currently owns the slave.
    always_comb begin
        own_req       = owner ? req_1        : req_0;
        own_read      = owner ? m1_read      : m0_read;
        own_write     = owner ? m1_write     : m0_write;
        own_address   = owner ? m1_address   : m0_address;
        own_writedata = owner ? m1_writedata : m0_writedata;
    end

    // The abort cycle is the grant cycle in which the watchdog has already
    // counted TIMEOUT stalled cycles; it replaces the slave's response.
    assign abort = granted && (TIMEOUT != 0) && (wd == WD_MAX);

    assign resp_wait = abort ? 1'b0     : s_waitrequest;
    assign resp_data = abort ? ERR_DATA : s_readdata;

    // Slave command: zero when idle; read+write together is issued as a
    // write; strobes are withdrawn in the abort cycle.
    always_comb begin
        s_address   = granted ? own_address   : 32'd0;
        s_writedata = granted ? own_writedata : 32'd0;
        s_write     = granted && own_write && !abort;
        s_read      = granted && own_read && !own_write && !abort;
    end

    // Requester responses: only the owner sees the slave, everyone else is
    // held off with waitrequest and zero readdata.
    always_comb begin
        m0_waitrequest = 1'b1;
        m0_readdata    = 32'd0;
        m1_waitrequest = 1'b1;
        m1_readdata    = 32'd0;
        if (granted && !owner) begin
            m0_waitrequest = resp_wait;
            m0_readdata    = resp_data;
        end
        if (granted && owner) begin
            m1_waitrequest = resp_wait;
            m1_readdata    = resp_data;
        end
    end

    assign timeout_err = abort;
    assign timeout_cnt = err_cnt;

    // Arbitration and transfer tracking. In IDLE the requester that was not
    // granted last wins a tie. A grant ends on completion or abort (both
    // update 'last'), or when the owner drops its request early, which
    // returns to IDLE without touching 'last' so the other side is not
    // penalised by a broken transfer.
    always_comb begin
        next_state = state;
        next_last  = last;
        case (state)
            IDLE: begin
                if (req_0 && req_1) begin
                    next_state = last ? GNT0 : GNT1;
                end else if (req_0) begin
                    next_state = GNT0;
                end else if (req_1) begin
                    next_state = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (abort) begin
                    next_state = IDLE;
                    next_last  = owner;
                end else if (!own_req) begin
                    next_state = IDLE;
                end else if (!s_waitrequest) begin
                    next_state = IDLE;
                    next_last  = owner;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State registers. The watchdog is cleared while idle, so every grant
    // starts counting from zero, and it advances on each stalled grant cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            wd      <= '0;
            err_cnt <= 8'd0;
        end else begin
            state <= next_state;
            last  <= next_last;
            if (state == IDLE) begin
                wd <= '0;
            end else if ((TIMEOUT != 0) && s_waitrequest && (wd != WD_MAX)) begin
                wd <= wd + WD_W'(1);
            end
            if (abort && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_s_arb2.sv
// ----------------------------------------------------------------------------
// tb_avmm_s_arb2
//
// Three arbiters (TIMEOUT = 8, 0 and 1) share one set of inputs. Every cycle
// each one is compared with a transaction-level model of the arbitration
// rules; directed sequences and a vector table add fixed expectations for
// the corner cases, and a random phase follows.
// ----------------------------------------------------------------------------
module tb_avmm_s_arb2;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic        reset_reset;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, s_readdata;
    logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;

    logic [31:0] m0_readdata_w [3];
    logic [31:0] m1_readdata_w [3];
    logic [31:0] s_address_w   [3];
    logic [31:0] s_writedata_w [3];
    logic        m0_waitrequest_w [3];
    logic        m1_waitrequest_w [3];
    logic        s_read_w      [3];
    logic        s_write_w     [3];
    logic        timeout_err_w [3];
    logic [7:0]  timeout_cnt_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        avmm_s_arb2 #(
            .TIMEOUT  ((g == 0) ? 8 : ((g == 1) ? 0 : 1)),
            .ERR_DATA (ERR)
        ) dut (
            .clk_clk        (clk_clk),
            .reset_reset    (reset_reset),
            .m0_address     (m0_address),
            .m0_read        (m0_read),
            .m0_write       (m0_write),
            .m0_writedata   (m0_writedata),
            .m0_readdata    (m0_readdata_w[g]),
            .m0_waitrequest (m0_waitrequest_w[g]),
            .m1_address     (m1_address),
            .m1_read        (m1_read),
            .m1_write       (m1_write),
            .m1_writedata   (m1_writedata),
            .m1_readdata    (m1_readdata_w[g]),
            .m1_waitrequest (m1_waitrequest_w[g]),
            .s_address      (s_address_w[g]),
            .s_read         (s_read_w[g]),
            .s_write        (s_write_w[g]),
            .s_writedata    (s_writedata_w[g]),
            .s_readdata     (s_readdata),
            .s_waitrequest  (s_waitrequest),
            .timeout_err    (timeout_err_w[g]),
            .timeout_cnt    (timeout_cnt_w[g])
        );
    end

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata0;
        logic        wait0;
        logic [31:0] rdata1;
        logic        wait1;
        logic        err;
        logic [7:0]  cnt;
    } obs_t;

    typedef struct {
        bit          r0, w0, r1, w1;
        logic [31:0] rdata;
        bit          expRd, expWr;
        logic [31:0] expAddr;
        bit          expWait0, expWait1;
        logic [31:0] expRdata0, expRdata1;
    } vec_t;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model: who owns the slave (-1 none), who was granted last, how many
    // cycles the current grant has stalled, and how many aborts so far.
    int toVal  [3];
    int mOwner [3];
    int mLast  [3];
    int mStall [3];
    int mCnt   [3];

    function automatic obs_t expectedObs(int i);
        obs_t e;
        bit ab;
        logic rd, wr;
        logic [31:0] ad, wd;
        e = '0;
        e.wait0 = 1'b1;
        e.wait1 = 1'b1;
        e.cnt = 8'(mCnt[i]);
        if (reset_reset || mOwner[i] < 0) return e;
        ab = (toVal[i] != 0) && (mStall[i] == toVal[i]);
        if (mOwner[i] == 0) begin
            rd = m0_read; wr = m0_write; ad = m0_address; wd = m0_writedata;
        end else begin
            rd = m1_read; wr = m1_write; ad = m1_address; wd = m1_writedata;
        end
        e.addr  = ad;
        e.wdata = wd;
        e.wr    = wr && !ab;
        e.rd    = rd && !wr && !ab;
        e.err   = ab;
        if (mOwner[i] == 0) begin
            e.wait0  = ab ? 1'b0 : s_waitrequest;
            e.rdata0 = ab ? ERR : s_readdata;
        end else begin
            e.wait1  = ab ? 1'b0 : s_waitrequest;
            e.rdata1 = ab ? ERR : s_readdata;
        end
        return e;
    endfunction

    function automatic obs_t actualObs(int i);
        obs_t a;
        a.addr   = s_address_w[i];
        a.rd     = s_read_w[i];
        a.wr     = s_write_w[i];
        a.wdata  = s_writedata_w[i];
        a.rdata0 = m0_readdata_w[i];
        a.wait0  = m0_waitrequest_w[i];
        a.rdata1 = m1_readdata_w[i];
        a.wait1  = m1_waitrequest_w[i];
        a.err    = timeout_err_w[i];
        a.cnt    = timeout_cnt_w[i];
        return a;
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic stepModels();
        for (int i = 0; i < 3; i++) begin
            if (reset_reset) begin
                mOwner[i] = -1; mLast[i] = 1; mStall[i] = 0; mCnt[i] = 0;
            end else if (mOwner[i] < 0) begin
                bit q0, q1;
                q0 = m0_read || m0_write;
                q1 = m1_read || m1_write;
                mStall[i] = 0;
                if (q0 && q1)  mOwner[i] = (mLast[i] == 0) ? 1 : 0;
                else if (q0)   mOwner[i] = 0;
                else if (q1)   mOwner[i] = 1;
            end else begin
                bit q, ab;
                int n;
                n  = mOwner[i];
                q  = (n == 0) ? (m0_read || m0_write) : (m1_read || m1_write);
                ab = (toVal[i] != 0) && (mStall[i] == toVal[i]);
                if (ab) begin
                    mOwner[i] = -1; mLast[i] = n;
                    mCnt[i] = (mCnt[i] < 255) ? mCnt[i] + 1 : 255;
                end else if (!q) begin
                    mOwner[i] = -1;
                end else if (!s_waitrequest) begin
                    mOwner[i] = -1; mLast[i] = n;
                end else begin
                    mStall[i]++;
                end
            end
        end
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 3; i++) begin
            obs_t e, a;
            e = expectedObs(i);
            a = actualObs(i);
            testsRun++;
            if (a !== e) begin
                testsFailed++;
                $display("[TB] FAIL model_dut%0d at %0t: got %h, expected %h", i, $time, a, e);
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [31:0] a1, input logic [31:0] d1,
                                 input logic sw, input logic [31:0] srd, input logic rst);
        m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1;
        s_waitrequest = sw; s_readdata = srd; reset_reset = rst;
    endtask

    task automatic idleInputs(input logic sw);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, sw, 0, 0);
    endtask

    task automatic sampleEdge();
        @(negedge clk_clk);
        checkOutput();
    endtask

    task automatic clockEdge();
        @(posedge clk_clk);
        stepModels();
        #1;
    endtask

    task automatic tick();
        sampleEdge();
        clockEdge();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] stopped by watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   order [4];
        int   pulses;
        int   idx, k0, k1;

        toVal = '{8, 0, 1};
        for (int i = 0; i < 3; i++) begin
            mOwner[i] = -1; mLast[i] = 1; mStall[i] = 0; mCnt[i] = 0;
        end

        // Reset, then a single zero-wait read from m0.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        clockEdge();
        tick();
        applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        sampleEdge();
        checkVal("t1_k_wait0", m0_waitrequest_w[0], 1);
        checkVal("t1_k_sread", s_read_w[0], 0);
        clockEdge();
        sampleEdge();
        checkVal("t1_k1_sread", s_read_w[0], 1);
        checkVal("t1_k1_addr", s_address_w[0], 32'h10);
        checkVal("t1_k1_rdata", m0_readdata_w[0], 32'h1234_5678);
        checkVal("t1_k1_wait0", m0_waitrequest_w[0], 0);
        clockEdge();
        idleInputs(0);
        sampleEdge();
        checkVal("t1_k2_sread", s_read_w[0], 0);
        checkVal("t1_k2_wait0", m0_waitrequest_w[0], 1);
        clockEdge();

        // Vector table: request pattern from IDLE, expected response in the
        // grant cycle. The round-robin pointer starts with m0 granted last.
        vecs[0] = '{1,0,0,0, 32'h1111_0000, 1,0, 32'h100, 0,1, 32'h1111_0000, 32'h0};
        vecs[1] = '{1,0,1,0, 32'h2222_0000, 1,0, 32'h200, 1,0, 32'h0, 32'h2222_0000};
        vecs[2] = '{0,1,1,0, 32'h3333_0000, 0,1, 32'h100, 0,1, 32'h3333_0000, 32'h0};
        vecs[3] = '{1,1,0,0, 32'h4444_0000, 0,1, 32'h100, 0,1, 32'h4444_0000, 32'h0};
        vecs[4] = '{0,0,0,1, 32'h5555_0000, 0,1, 32'h200, 1,0, 32'h0, 32'h5555_0000};
        vecs[5] = '{0,1,0,1, 32'h6666_0000, 0,1, 32'h100, 0,1, 32'h6666_0000, 32'h0};
        vecs[6] = '{1,0,1,1, 32'h7777_0000, 0,1, 32'h200, 1,0, 32'h0, 32'h7777_0000};
        vecs[7] = '{0,0,0,0, 32'h8888_0000, 0,0, 32'h0,   1,1, 32'h0, 32'h0};
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].r0, vecs[v].w0, 32'h100, 32'hA0A0_0000,
                          vecs[v].r1, vecs[v].w1, 32'h200, 32'hB1B1_0000,
                          0, vecs[v].rdata, 0);
            tick();
            sampleEdge();
            checkVal($sformatf("vec%0d_cmd", v),
                     {29'd0, s_read_w[0], s_write_w[0], m0_waitrequest_w[0]},
                     {29'd0, vecs[v].expRd, vecs[v].expWr, vecs[v].expWait0});
            checkVal($sformatf("vec%0d_wait1", v), m1_waitrequest_w[0], vecs[v].expWait1);
            checkVal($sformatf("vec%0d_addr", v), s_address_w[0], vecs[v].expAddr);
            checkVal($sformatf("vec%0d_rd0", v), m0_readdata_w[0], vecs[v].expRdata0);
            checkVal($sformatf("vec%0d_rd1", v), m1_readdata_w[0], vecs[v].expRdata1);
            clockEdge();
            idleInputs(0);
            tick();
        end

        // Continuous contention: both write back-to-back, grants alternate.
        order = '{0, 1, 0, 1};
        idx = 0; k0 = 0; k1 = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            int gnt;
            applyStimulus(0, 1, 32'h300, 32'hC000_0000 + k0, 0, 1, 32'h304, 32'hD000_0000 + k1, 0, 0, 0);
            sampleEdge();
            gnt = -1;
            if (m0_waitrequest_w[0] == 1'b0) gnt = 0;
            else if (m1_waitrequest_w[0] == 1'b0) gnt = 1;
            if (gnt >= 0) begin
                checkVal("cont_owner", gnt, order[idx]);
                checkVal("cont_wdata", s_writedata_w[0],
                         (order[idx] == 0) ? 32'hC000_0000 + k0 : 32'hD000_0000 + k1);
                idx++;
            end
            clockEdge();
            if (gnt == 0) k0++;
            if (gnt == 1) k1++;
        end
        checkVal("cont_count", idx, 4);
        idleInputs(0);
        tick();

        // m1 write stalls 5 cycles while m0 read waits behind it.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h400, 32'hE0E0_E0E0, 1, 0, 0);
        tick();
        for (int g = 1; g <= 6; g++) begin
            applyStimulus(1, 0, 32'h500, 0, 0, 1, 32'h400, 32'hE0E0_E0E0, (g <= 5), 0, 0);
            sampleEdge();
            checkVal("stall_wait0", m0_waitrequest_w[0], 1);
            checkVal("stall_wait1", m1_waitrequest_w[0], (g <= 5) ? 1 : 0);
            clockEdge();
        end
        applyStimulus(1, 0, 32'h500, 0, 0, 0, 0, 0, 0, 32'h55AA_55AA, 0);
        sampleEdge();
        checkVal("stall_idle_wait0", m0_waitrequest_w[0], 1);
        clockEdge();
        sampleEdge();
        checkVal("stall_m0_gnt", m0_waitrequest_w[0], 0);
        checkVal("stall_m0_rdata", m0_readdata_w[0], 32'h55AA_55AA);
        clockEdge();
        idleInputs(0);
        tick();

        // Hung slave on an m0 read: abort on grant cycle 9 (TIMEOUT = 8).
        applyStimulus(1, 0, 32'h600, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 0);
        tick();
        pulses = 0;
        for (int g = 1; g <= 9; g++) begin
            sampleEdge();
            if (g < 9) begin
                checkVal("abort_pre_wait0", m0_waitrequest_w[0], 1);
            end else begin
                checkVal("abort_wait0", m0_waitrequest_w[0], 0);
                checkVal("abort_rdata", m0_readdata_w[0], ERR);
                checkVal("abort_sread", s_read_w[0], 0);
            end
            pulses += int'(timeout_err_w[0]);
            clockEdge();
        end
        idleInputs(1);
        for (int c = 0; c < 3; c++) begin
            sampleEdge();
            pulses += int'(timeout_err_w[0]);
            clockEdge();
        end
        checkVal("abort_pulses", pulses, 1);
        checkVal("abort_cnt", timeout_cnt_w[0], 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h700, 32'h7777_7777, 0, 0, 0);
        tick();
        sampleEdge();
        checkVal("post_abort_m1_wait", m1_waitrequest_w[0], 0);
        checkVal("post_abort_m1_wdata", s_writedata_w[0], 32'h7777_7777);
        clockEdge();
        idleInputs(0);
        tick();

        // Reset in the middle of a stalled read.
        applyStimulus(1, 0, 32'h800, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        tick();
        tick();
        applyStimulus(1, 0, 32'h800, 0, 0, 0, 0, 0, 1, 0, 1);
        sampleEdge();
        checkVal("rst_during_sread", s_read_w[0], 0);
        checkVal("rst_during_wait0", m0_waitrequest_w[0], 1);
        clockEdge();
        applyStimulus(0, 1, 32'h900, 32'h11, 0, 1, 32'h904, 32'h22, 0, 0, 0);
        sampleEdge();
        checkVal("rst_after_swrite", s_write_w[0], 0);
        checkVal("rst_after_wait0", m0_waitrequest_w[0], 1);
        checkVal("rst_after_wait1", m1_waitrequest_w[0], 1);
        checkVal("rst_after_cnt", timeout_cnt_w[0], 0);
        clockEdge();
        sampleEdge();
        checkVal("rst_first_wait0", m0_waitrequest_w[0], 0);
        checkVal("rst_first_wait1", m1_waitrequest_w[0], 1);
        checkVal("rst_first_wdata", s_writedata_w[0], 32'h11);
        clockEdge();
        idleInputs(0);
        tick();

        // TIMEOUT = 0 instance: a 2000-cycle stall never aborts.
        applyStimulus(1, 0, 32'hA00, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 2001; c++) tick();
        sampleEdge();
        checkVal("to0_cnt", timeout_cnt_w[1], 0);
        checkVal("to0_wait0", m0_waitrequest_w[1], 1);
        clockEdge();
        applyStimulus(1, 0, 32'hA00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idleInputs(0);
        tick();

        // TIMEOUT = 1 instance: hundreds of aborts saturate the counter.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(1, 0, 32'hB00, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 800; c++) tick();
        sampleEdge();
        checkVal("sat_cnt", timeout_cnt_w[2], 255);
        clockEdge();
        idleInputs(0);
        tick();

        // Random traffic against the model; requesters hold their command
        // until the model says their transfer has finished.
        begin
            bit p0, p1, rst, sw;
            logic r0, w0, r1, w1;
            logic [31:0] a0, d0, a1, d1;
            int op;
            obs_t e;
            p0 = 0; p1 = 0;
            r0 = 0; w0 = 0; r1 = 0; w1 = 0;
            a0 = 0; d0 = 0; a1 = 0; d1 = 0;
            for (int c = 0; c < 3000; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                if (!p0 && $urandom_range(0, 1) == 1) begin
                    p0 = 1; op = $urandom_range(0, 2);
                    r0 = (op != 1); w0 = (op != 0); a0 = $urandom; d0 = $urandom;
                end
                if (!p0) begin r0 = 0; w0 = 0; end
                if (!p1 && $urandom_range(0, 1) == 1) begin
                    p1 = 1; op = $urandom_range(0, 2);
                    r1 = (op != 1); w1 = (op != 0); a1 = $urandom; d1 = $urandom;
                end
                if (!p1) begin r1 = 0; w1 = 0; end
                sw = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                applyStimulus(r0, w0, a0, d0, r1, w1, a1, d1, sw, $urandom, rst);
                sampleEdge();
                e = expectedObs(0);
                if (rst) begin
                    p0 = 0; p1 = 0;
                end else begin
                    if (p0 && !e.wait0) p0 = 0;
                    if (p1 && !e.wait1) p1 = 0;
                end
                clockEdge();
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
